discharge_pulse_sequencer: RTL and testbench

// Per-pulse EDM discharge sequencer in the clk_100M domain, between the SPI command registers and the MOSFET gate drivers.

---
 rtl/discharge_pulse_sequencer_if.sv | 34 +++
 rtl/discharge_pulse_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_discharge_pulse_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/discharge_pulse_sequencer_if.sv
// Command/status bundle between the SPI register block and the EDM discharge sequencer.
// Build option carried by the sequencer itself: SHORT_CUT_EN.
interface discharge_pulse_sequencer_if #(
    parameter int ADC_W = 16,
    parameter int CNT_W = 16
);
    // start/stop are single-cycle synchronised strobes with no back-pressure;
    // pulse_done is a 1-cycle strobe and pulse_class is only meaningful while it is high.
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] ton_cycles;
    logic [CNT_W-1:0] toff_cycles;
    logic [ADC_W-1:0] v_brk_th;
    logic [ADC_W-1:0] sample_voltage;
    logic             cnt_clear;
    logic             gate_on;
    logic             deion_on;
    logic [2:0]       phase;
    logic             pulse_done;
    logic [1:0]       pulse_class;
    logic [7:0]       null_cnt;
    logic [7:0]       normal_cnt;
    logic [7:0]       short_cnt;

    modport master (
        output start, stop, ton_cycles, toff_cycles, v_brk_th, sample_voltage, cnt_clear,
        input  gate_on, deion_on, phase, pulse_done, pulse_class, null_cnt, normal_cnt, short_cnt
    );

    modport slave (
        input  start, stop, ton_cycles, toff_cycles, v_brk_th, sample_voltage, cnt_clear,
        output gate_on, deion_on, phase, pulse_done, pulse_class, null_cnt, normal_cnt, short_cnt
    );
endinterface

// File: rtl/discharge_pulse_sequencer.sv
// Per-pulse EDM discharge sequencer: OPEN -> TON -> DEAD -> TOFF with NULL/NORMAL/SHORT sorting.
// Optional macro SHORT_CUT_EN: SHORT pulses skip TON and go straight to the dead band.
module discharge_pulse_sequencer #(
    parameter int ADC_W     = 16,
    parameter int CNT_W     = 16,
    parameter int MAX_WAIT  = 10000,
    parameter int SHORT_DLY = 8,
    parameter int DEAD_CYC  = 5
) (
    input logic clk,
    input logic rst_n,
    discharge_pulse_sequencer_if.slave bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OPEN = 3'd1,
        S_TON  = 3'd2,
        S_DEAD = 3'd3,
        S_TOFF = 3'd4
    } state_t;

    localparam logic [1:0]        CL_NULL   = 2'd0;
    localparam logic [1:0]        CL_NORMAL = 2'd1;
    localparam logic [1:0]        CL_SHORT  = 2'd2;
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] SHORT_LIM = WAIT_W'(SHORT_DLY);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ton_lat_q, ton_lat_d;
    logic [CNT_W-1:0]  toff_lat_q, toff_lat_d;
    logic              stop_pend_q, stop_pend_d;
    logic [1:0]        class_q, class_d;
    logic              gate_on_q, gate_on_d;
    logic              deion_on_q, deion_on_d;
    logic [2:0]        phase_q, phase_d;
    logic              pulse_done_q, pulse_done_d;
    logic [1:0]        pulse_class_q, pulse_class_d;
    logic [7:0]        null_cnt_q, null_cnt_d;
    logic [7:0]        normal_cnt_q, normal_cnt_d;
    logic [7:0]        short_cnt_q, short_cnt_d;

    logic [ADC_W-1:0]  v_s;
    logic [ADC_W-1:0]  th_s;
    logic              brk;
    logic              is_short;

    assign v_s      = bus.sample_voltage;
    assign th_s     = bus.v_brk_th;
    assign brk      = (v_s < th_s);
    assign is_short = (wait_cnt_q < SHORT_LIM);

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        cnt_d        = cnt_q;
        ton_lat_d    = ton_lat_q;
        toff_lat_d   = toff_lat_q;
        stop_pend_d  = stop_pend_q;
        class_d      = class_q;
        null_cnt_d   = null_cnt_q;
        normal_cnt_d = normal_cnt_q;
        short_cnt_d  = short_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d = S_OPEN;
                end
            end
            S_OPEN: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                    state_d     = S_DEAD;
                    cnt_d       = '0;
                end else if (brk) begin
                    class_d = is_short ? CL_SHORT : CL_NORMAL;
                    cnt_d   = '0;
`ifdef SHORT_CUT_EN
                    state_d = is_short ? S_DEAD : S_TON;
`else
                    state_d = S_TON;
`endif
                end else if (wait_cnt_q == WAIT_LAST) begin
                    class_d = CL_NULL;
                    state_d = S_DEAD;
                    cnt_d   = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_TON: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                    state_d     = S_DEAD;
                    cnt_d       = '0;
                end else if (cnt_q == ton_lat_q - ONE) begin
                    state_d = S_DEAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_DEAD: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_q == DEAD_LAST) begin
                    state_d = stop_pend_d ? S_IDLE : S_TOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_TOFF: begin
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_q == toff_lat_q - ONE) begin
                    // Counters bump as the pulse_done cycle closes.
                    case (class_q)
                        CL_NULL:   if (null_cnt_q   != 8'hFF) null_cnt_d   = null_cnt_q   + 8'd1;
                        CL_NORMAL: if (normal_cnt_q != 8'hFF) normal_cnt_d = normal_cnt_q + 8'd1;
                        default:   if (short_cnt_q  != 8'hFF) short_cnt_d  = short_cnt_q  + 8'd1;
                    endcase
                    state_d = stop_pend_d ? S_IDLE : S_OPEN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timing is frozen per pulse: a new Ton/Toff only takes effect at the next OPEN.
        if (state_d == S_OPEN && state_q != S_OPEN) begin
            wait_cnt_d = '0;
            ton_lat_d  = (bus.ton_cycles  == '0) ? ONE : bus.ton_cycles;
            toff_lat_d = (bus.toff_cycles == '0) ? ONE : bus.toff_cycles;
        end
        if (state_d == S_IDLE) begin
            stop_pend_d = 1'b0;
        end
        if (bus.cnt_clear) begin
            null_cnt_d   = '0;
            normal_cnt_d = '0;
            short_cnt_d  = '0;
        end

        gate_on_d     = (state_d == S_OPEN) || (state_d == S_TON);
        deion_on_d    = (state_d == S_TOFF);
        phase_d       = state_d;
        pulse_done_d  = (state_d == S_TOFF) && (cnt_d == toff_lat_d - ONE);
        pulse_class_d = pulse_done_d ? class_d : CL_NULL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            cnt_q         <= '0;
            ton_lat_q     <= ONE;
            toff_lat_q    <= ONE;
            stop_pend_q   <= 1'b0;
            class_q       <= CL_NULL;
            gate_on_q     <= 1'b0;
            deion_on_q    <= 1'b0;
            phase_q       <= 3'd0;
            pulse_done_q  <= 1'b0;
            pulse_class_q <= 2'd0;
            null_cnt_q    <= '0;
            normal_cnt_q  <= '0;
            short_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            cnt_q         <= cnt_d;
            ton_lat_q     <= ton_lat_d;
            toff_lat_q    <= toff_lat_d;
            stop_pend_q   <= stop_pend_d;
            class_q       <= class_d;
            gate_on_q     <= gate_on_d;
            deion_on_q    <= deion_on_d;
            phase_q       <= phase_d;
            pulse_done_q  <= pulse_done_d;
            pulse_class_q <= pulse_class_d;
            null_cnt_q    <= null_cnt_d;
            normal_cnt_q  <= normal_cnt_d;
            short_cnt_q   <= short_cnt_d;
        end
    end

    assign bus.gate_on     = gate_on_q;
    assign bus.deion_on    = deion_on_q;
    assign bus.phase       = phase_q;
    assign bus.pulse_done  = pulse_done_q;
    assign bus.pulse_class = pulse_class_q;
    assign bus.null_cnt    = null_cnt_q;
    assign bus.normal_cnt  = normal_cnt_q;
    assign bus.short_cnt   = short_cnt_q;
endmodule

// File: tb/tb_discharge_pulse_sequencer.sv
// Bench for discharge_pulse_sequencer: directed pulses, scoreboard on pulse_done, counter and reset checks.
module tb_discharge_pulse_sequencer;
    localparam int DEAD_CYC = 5;
    localparam int MAX_WAIT = 100;
    localparam int W        = 50;
`ifdef SHORT_CUT_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   pulses_seen;
    int   brk_at;
    logic [W-1:0] exp_q[$];

    discharge_pulse_sequencer_if #(.ADC_W(16), .CNT_W(16)) bus ();

    discharge_pulse_sequencer #(
        .ADC_W(16), .CNT_W(16), .MAX_WAIT(MAX_WAIT), .SHORT_DLY(8), .DEAD_CYC(DEAD_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gap model: voltage collapses once OPEN has lasted brk_at cycles
    int open_cnt;
    logic [2:0] prev_phase_g;
    always @(negedge clk) begin
        if (bus.phase == 3'd1) open_cnt = (prev_phase_g == 3'd1) ? open_cnt + 1 : 0;
        bus.sample_voltage = (bus.phase == 3'd1 && open_cnt >= brk_at) ? 16'd100 : 16'd5000;
        prev_phase_g = bus.phase;
    end

    function automatic logic [W-1:0] pack(input logic [1:0] c, input int g, input int t);
        return {c, 16'(g), 16'(DEAD_CYC), 16'(t)};
    endfunction

    // monitor / scoreboard
    int gate_run, zero_run, deion_run, last_gate;
    logic prev_gate, prev_deion;
    logic [W-1:0] act, e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_gate = 1'b0; prev_deion = 1'b0;
            gate_run = 0; zero_run = 0; deion_run = 0; last_gate = 0;
        end else begin
            checks++;
            if (bus.gate_on && bus.deion_on) begin
                failures++;
                $display("FAIL overlap: gate_on=1 deion_on=1 at %0t, required not both", $time);
            end
            if (bus.gate_on) gate_run = prev_gate ? gate_run + 1 : 1;
            else if (prev_gate) begin last_gate = gate_run; zero_run = 0; end
            if (!bus.gate_on && !bus.deion_on) zero_run++;
            if (bus.deion_on) deion_run = prev_deion ? deion_run + 1 : 1;
            if (bus.pulse_done) begin
                pulses_seen++;
                act = {bus.pulse_class, 16'(last_gate), 16'(zero_run), 16'(deion_run)};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_pulse_done: class=%0d gate=%0d at %0t, required none",
                             bus.pulse_class, last_gate, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        failures++;
                        $display("FAIL pulse%0d: class=%0d gate=%0d zero=%0d deion=%0d, required class=%0d gate=%0d zero=%0d deion=%0d",
                                 pulses_seen, act[49:48], act[47:32], act[31:16], act[15:0],
                                 e[49:48], e[47:32], e[31:16], e[15:0]);
                    end
                end
            end
            prev_gate = bus.gate_on;
            prev_deion = bus.deion_on;
        end
    end

    // driver tasks
    task automatic check(input string name, input logic [15:0] a, input logic [15:0] x);
        checks++;
        if (a !== x) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, a, x);
        end
    endtask

    task automatic wait_phase(input logic [2:0] p, input int max_cyc, input string name);
        int n;
        n = 0;
        while (bus.phase !== p && n < max_cyc) begin @(negedge clk); n++; end
        checks++;
        if (bus.phase !== p) begin
            failures++;
            $display("FAIL %s: phase=%0d required %0d within %0d cycles", name, bus.phase, p, max_cyc);
        end
    endtask

    task automatic wait_seen(input int target, input int max_cyc, input string name);
        int n;
        n = 0;
        while (pulses_seen < target && n < max_cyc) begin @(negedge clk); n++; end
        checks++;
        if (pulses_seen < target) begin
            failures++;
            $display("FAIL %s: pulses=%0d required %0d", name, pulses_seen, target);
        end
    endtask

    task automatic kick_start();
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
    endtask

    task automatic single_pulse(input int ton, input int toff, input int brk, input logic [1:0] cls,
                                input int gate_len, input bit do_clear);
        bus.ton_cycles = 16'(ton); bus.toff_cycles = 16'(toff); brk_at = brk;
        exp_q.push_back(pack(cls, gate_len, (toff == 0) ? 1 : toff));
        kick_start();
        wait_phase(3'd4, 2000, "reach_toff");
        if (do_clear) begin
            int n;
            n = 0;
            while (!bus.pulse_done && n < 100) begin @(negedge clk); n++; end
        end
        bus.cnt_clear = do_clear; bus.stop = 1'b1;
        @(negedge clk); bus.cnt_clear = 1'b0; bus.stop = 1'b0;
        wait_phase(3'd0, 2000, "reach_idle");
    endtask

    task automatic run_train(input int n, input int ton, input int ton2, input int toff, input int brk,
                             input logic [1:0] cls);
        int base;
        base = pulses_seen;
        bus.ton_cycles = 16'(ton); bus.toff_cycles = 16'(toff); brk_at = brk;
        for (int i = 0; i < n; i++) exp_q.push_back(pack(cls, brk + 1 + ((i == 0) ? ton : ton2), toff));
        kick_start();
        if (ton2 != ton) begin
            wait_phase(3'd2, 2000, "train_ton");
            bus.ton_cycles = 16'(ton2);
        end
        if (n > 1) begin
            wait_seen(base + n - 1, n * 100, "train_progress");
            @(negedge clk);
        end
        wait_phase(3'd4, 2000, "train_toff");
        bus.stop = 1'b1;
        @(negedge clk); bus.stop = 1'b0;
        wait_phase(3'd0, 2000, "train_idle");
    endtask

    initial begin
        checks = 0; failures = 0; pulses_seen = 0; brk_at = 1000000;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cnt_clear = 1'b0;
        bus.ton_cycles = 16'd10; bus.toff_cycles = 16'd20; bus.v_brk_th = 16'd1000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gate_on", 16'(bus.gate_on), 16'd0);
        check("rst_deion_on", 16'(bus.deion_on), 16'd0);
        check("rst_phase", 16'(bus.phase), 16'd0);
        check("rst_pulse_done", 16'(bus.pulse_done), 16'd0);
        check("rst_counters", 16'(bus.null_cnt | bus.normal_cnt | bus.short_cnt), 16'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // normal, short, null, boundary classes
        single_pulse(10, 20, 50, 2'd1, 61, 1'b0);
        check("t1_normal_cnt", 16'(bus.normal_cnt), 16'd1);
        single_pulse(10, 3, 0, 2'd2, SC ? 1 : 11, 1'b0);
        check("t2_short_cnt", 16'(bus.short_cnt), 16'd1);
        single_pulse(5, 4, 1000000, 2'd0, MAX_WAIT, 1'b0);
        check("t3_null_cnt", 16'(bus.null_cnt), 16'd1);
        single_pulse(3, 1, 7, 2'd2, SC ? 8 : 11, 1'b0);
        check("b_c7_short_cnt", 16'(bus.short_cnt), 16'd2);
        single_pulse(0, 0, 8, 2'd1, 10, 1'b0);
        check("b_c8_normal_cnt", 16'(bus.normal_cnt), 16'd2);

        // stop on third TON cycle
        bus.ton_cycles = 16'd10; bus.toff_cycles = 16'd5; brk_at = 5;
        kick_start();
        wait_phase(3'd2, 200, "t4_reach_ton");
        repeat (2) @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk); bus.stop = 1'b0;
        check("t4_gate_off", 16'(bus.gate_on), 16'd0);
        check("t4_phase_dead", 16'(bus.phase), 16'd3);
        repeat (4) @(negedge clk);
        check("t4_dead_last", 16'(bus.phase), 16'd3);
        @(negedge clk);
        check("t4_idle", 16'(bus.phase), 16'd0);
        check("t4_normal_cnt", 16'(bus.normal_cnt), 16'd2);
        check("t4_short_cnt", 16'(bus.short_cnt), 16'd2);
        check("t4_null_cnt", 16'(bus.null_cnt), 16'd1);

        // saturation, then Ton change mid-pulse
        run_train(300, 2, 2, 2, 8, 2'd1);
        check("t5_normal_sat", 16'(bus.normal_cnt), 16'd255);
        run_train(2, 4, 7, 3, 10, 2'd1);
        check("t5_normal_hold", 16'(bus.normal_cnt), 16'd255);

        // async reset in the middle of TOFF
        bus.ton_cycles = 16'd3; bus.toff_cycles = 16'd50; brk_at = 2;
        kick_start();
        wait_phase(3'd4, 200, "t6_reach_toff");
        repeat (5) @(negedge clk);
        check("t6_pre_deion", 16'(bus.deion_on), 16'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_deion", 16'(bus.deion_on), 16'd0);
        check("t6_phase", 16'(bus.phase), 16'd0);
        check("t6_normal_cnt", 16'(bus.normal_cnt), 16'd0);
        check("t6_short_cnt", 16'(bus.short_cnt), 16'd0);
        check("t6_null_cnt", 16'(bus.null_cnt), 16'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // clear coincident with pulse_done wins over the increment
        single_pulse(2, 2, 3, 2'd2, SC ? 4 : 6, 1'b0);
        check("t7_short_cnt", 16'(bus.short_cnt), 16'd1);
        single_pulse(2, 3, 3, 2'd2, SC ? 4 : 6, 1'b1);
        check("t7_clear_short", 16'(bus.short_cnt), 16'd0);
        check("t7_clear_normal", 16'(bus.normal_cnt), 16'd0);

        // start and stop together in IDLE
        brk_at = 0;
        @(negedge clk); bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk); bus.start = 1'b0; bus.stop = 1'b0;
        check("t8_phase", 16'(bus.phase), 16'd0);
        repeat (3) @(negedge clk);
        check("t8_phase_hold", 16'(bus.phase), 16'd0);
        check("t8_gate", 16'(bus.gate_on), 16'd0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
